// File: rtl/mux_sel_sequencer.sv
// Scan sequencer for an 8-to-1 mux: steps the select code through all eight inputs,
// samples the fed-back mux output at the end of each hold window and assembles a byte.
module mux_sel_sequencer #(
    parameter int unsigned HOLD = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       msb_first,
    input  logic       mux_out,
    output logic       sel0,
    output logic       sel1,
    output logic       sel2,
    output logic       bit_valid,
    output logic       busy,
    output logic       done,
    output logic [7:0] data_out
);

    // HOLD = 0 behaves exactly like HOLD = 1
    localparam int unsigned HOLD_EFF  = (HOLD == 0) ? 1 : HOLD;
    localparam logic [3:0]  HOLD_LAST = 4'(HOLD_EFF - 1);

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DONE
    } state_t;

    state_t     r_state, w_state_nxt;
    logic [2:0] r_sel, w_sel_nxt;
    logic [3:0] r_hold, w_hold_nxt;
    logic [2:0] r_bitcnt, w_bitcnt_nxt;
    logic       r_msb, w_msb_nxt;
    logic [7:0] r_cap, w_cap_nxt;
    logic [7:0] r_data, w_data_nxt;
    logic       w_bit_valid;
    logic       w_last;

    always_comb begin
        w_state_nxt  = r_state;
        w_sel_nxt    = r_sel;
        w_hold_nxt   = r_hold;
        w_bitcnt_nxt = r_bitcnt;
        w_msb_nxt    = r_msb;
        w_cap_nxt    = r_cap;
        w_data_nxt   = r_data;
        w_bit_valid  = (r_state == SCAN) && (r_hold == HOLD_LAST);
        w_last       = w_bit_valid && (r_bitcnt == 3'd7);

        case (r_state)
            IDLE: begin
                w_sel_nxt = '0;
                if (start) begin
                    w_state_nxt  = SCAN;
                    w_msb_nxt    = msb_first;
                    w_sel_nxt    = msb_first ? '1 : '0;
                    w_hold_nxt   = '0;
                    w_bitcnt_nxt = '0;
                    w_cap_nxt    = '0;
                end
            end
            SCAN: begin
                if (w_bit_valid) begin
                    w_cap_nxt[r_sel] = mux_out;
                    w_hold_nxt       = '0;
                    w_bitcnt_nxt     = r_bitcnt + 3'd1;
                    // final code: publish including the bit captured on this very edge
                    if (w_last) begin
                        w_state_nxt = DONE;
                        w_sel_nxt   = '0;
                        w_data_nxt  = w_cap_nxt;
                    end else begin
                        w_sel_nxt = r_msb ? (r_sel - 3'd1) : (r_sel + 3'd1);
                    end
                end else begin
                    w_hold_nxt = r_hold + 4'd1;
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
                w_sel_nxt   = '0;
            end
            default: begin
                w_state_nxt = IDLE;
                w_sel_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_sel    <= '0;
            r_hold   <= '0;
            r_bitcnt <= '0;
            r_msb    <= 1'b0;
            r_cap    <= '0;
            r_data   <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_sel    <= w_sel_nxt;
            r_hold   <= w_hold_nxt;
            r_bitcnt <= w_bitcnt_nxt;
            r_msb    <= w_msb_nxt;
            r_cap    <= w_cap_nxt;
            r_data   <= w_data_nxt;
        end
    end

    assign sel0      = r_sel[0];
    assign sel1      = r_sel[1];
    assign sel2      = r_sel[2];
    assign bit_valid = w_bit_valid;
    assign busy      = (r_state == SCAN);
    assign done      = (r_state == DONE);
    assign data_out  = r_data;

endmodule

// File: tb/tb_mux_sel_sequencer.sv
// Bench for mux_sel_sequencer: HOLD=1 and HOLD=3 instances share stimulus and are checked
// every cycle against a cycle-index model, plus literal expectations from directed scans.
module tb_mux_sel_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       msb_first = 1'b0;
    logic [7:0] mux_in = 8'h00;

    logic [1:0] sel0, sel1, sel2, bv, busy, done, mux_out;
    logic [7:0] dout [2];

    int checks = 0;
    int errors = 0;
    bit en = 1'b0;

    localparam int HV [2] = '{1, 3};

    always #5 clk = ~clk;

    assign mux_out[0] = mux_in[{sel2[0], sel1[0], sel0[0]}];
    assign mux_out[1] = mux_in[{sel2[1], sel1[1], sel0[1]}];

    mux_sel_sequencer #(.HOLD(1)) u_h1 (
        .clk(clk), .rst(rst), .start(start), .msb_first(msb_first), .mux_out(mux_out[0]),
        .sel0(sel0[0]), .sel1(sel1[0]), .sel2(sel2[0]), .bit_valid(bv[0]),
        .busy(busy[0]), .done(done[0]), .data_out(dout[0])
    );

    mux_sel_sequencer #(.HOLD(3)) u_h3 (
        .clk(clk), .rst(rst), .start(start), .msb_first(msb_first), .mux_out(mux_out[1]),
        .sel0(sel0[1]), .sel1(sel1[1]), .sel2(sel2[1]), .bit_valid(bv[1]),
        .busy(busy[1]), .done(done[1]), .data_out(dout[1])
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Model: mc = index of the current cycle within a scan (0 = idle, 1..8H scanning, 8H+1 done)
    int         mc    [2] = '{0, 0};
    bit         mord  [2] = '{1'b0, 1'b0};
    logic [7:0] mcap  [2] = '{8'h00, 8'h00};
    logic [7:0] mdata [2] = '{8'h00, 8'h00};

    function automatic int code_of(input bit msb, input int n);
        return msb ? 7 - n : n;
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            int h;
            int cd;
            h = HV[i];
            if (rst) begin
                mc[i] = 0; mcap[i] = 8'h00; mdata[i] = 8'h00;
            end else if (mc[i] == 0) begin
                if (start) begin
                    mc[i] = 1; mord[i] = msb_first; mcap[i] = 8'h00;
                end
            end else if (mc[i] <= 8 * h) begin
                if (mc[i] % h == 0) begin
                    cd = code_of(mord[i], mc[i] / h - 1);
                    mcap[i][cd] = mux_in[cd];
                    if (mc[i] == 8 * h) mdata[i] = mcap[i];
                end
                mc[i] = mc[i] + 1;
            end else begin
                mc[i] = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (en) begin
            for (int i = 0; i < 2; i++) begin
                int h;
                int c;
                bit eb;
                h = HV[i];
                c = mc[i];
                eb = (c >= 1) && (c <= 8 * h);
                chk($sformatf("busy%0d", i), busy[i], eb);
                chk($sformatf("done%0d", i), done[i], c == 8 * h + 1);
                chk($sformatf("bit_valid%0d", i), bv[i], eb && (c % h == 0));
                chk($sformatf("sel%0d", i), {sel2[i], sel1[i], sel0[i]},
                    eb ? code_of(mord[i], (c - 1) / h) : 0);
                chk($sformatf("data_out%0d", i), dout[i], mdata[i]);
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Start a scan in cycle 0 and watch 40 cycles; returns done cycles, data and busy/bit_valid counts.
    task automatic run_scan(input bit msb, input logic [7:0] v0, input bit mid,
                            output int got0, output int got1, output logic [7:0] d0,
                            output logic [7:0] d1, output int nb1, output int nv1);
        got0 = 0; got1 = 0; d0 = 8'h00; d1 = 8'h00; nb1 = 0; nv1 = 0;
        @(negedge clk);
        start = 1'b1; msb_first = msb; mux_in = v0;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(negedge clk);
            if (cyc == 1) start = 1'b0;
            if (mid && cyc == 2) mux_in[0] = 1'b0;
            if (mid && cyc == 5) mux_in[7] = 1'b1;
            if (done[0]) begin got0 = cyc; d0 = dout[0]; end
            if (done[1]) begin got1 = cyc; d1 = dout[1]; end
            if (busy[1]) nb1++;
            if (bv[1]) nv1++;
        end
    endtask

    initial begin
        int g0, g1, nb1, nv1, n0, n1, f0, s0;
        logic [7:0] d0, d1;

        idle(3);
        rst = 1'b0;
        en = 1'b1;
        chk("reset_data0", dout[0], 8'h00);
        chk("reset_sel0", {sel2[0], sel1[0], sel0[0]}, 0);

        run_scan(1'b0, 8'hB2, 1'b0, g0, g1, d0, d1, nb1, nv1);
        chk("lsb_done_cyc_h1", g0, 9);
        chk("lsb_done_cyc_h3", g1, 25);
        chk("lsb_data_h1", d0, 8'hB2);
        chk("lsb_data_h3", d1, 8'hB2);
        chk("model_lsb_h1", mdata[0], 8'hB2);

        run_scan(1'b1, 8'hB2, 1'b0, g0, g1, d0, d1, nb1, nv1);
        chk("msb_done_cyc_h1", g0, 9);
        chk("msb_data_h1", d0, 8'hB2);
        chk("msb_data_h3", d1, 8'hB2);

        run_scan(1'b0, 8'hFF, 1'b0, g0, g1, d0, d1, nb1, nv1);
        chk("ones_data_h3", d1, 8'hFF);
        chk("ones_busy_cycles_h3", nb1, 24);
        chk("ones_bv_cycles_h3", nv1, 8);
        chk("model_ones_h3", mdata[1], 8'hFF);

        run_scan(1'b0, 8'h01, 1'b1, g0, g1, d0, d1, nb1, nv1);
        chk("midscan_data_h1", d0, 8'h81);
        chk("midscan_data_h3", d1, 8'h80);
        chk("model_midscan_h1", mdata[0], 8'h81);

        // start held high continuously
        @(negedge clk);
        start = 1'b1; msb_first = 1'b0; mux_in = 8'h5A;
        n0 = 0; n1 = 0; f0 = 0; s0 = 0;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(negedge clk);
            if (done[0]) begin
                n0++;
                if (n0 == 1) f0 = cyc;
                if (n0 == 2) s0 = cyc;
            end
            if (done[1]) n1++;
        end
        start = 1'b0;
        chk("held_done_count_h1", n0, 4);
        chk("held_done_count_h3", n1, 1);
        chk("held_first_done_h1", f0, 9);
        chk("held_second_done_h1", s0, 19);
        idle(30);

        // reset in cycle 4 of an active scan, held for two cycles
        @(negedge clk);
        start = 1'b1; mux_in = 8'hC3;
        @(negedge clk);
        start = 1'b0;
        idle(3);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_busy_h1", busy[0], 1'b0);
        chk("rst_sel_h1", {sel2[0], sel1[0], sel0[0]}, 0);
        chk("rst_bv_h1", bv[0], 1'b0);
        chk("rst_done_h1", done[0], 1'b0);
        chk("rst_data_h1", dout[0], 8'h00);
        chk("rst_data_h3", dout[1], 8'h00);
        @(negedge clk);
        rst = 1'b0;
        n0 = 0;
        for (int cyc = 0; cyc < 30; cyc++) begin
            @(negedge clk);
            if (done[0] || done[1]) n0++;
        end
        chk("rst_no_done", n0, 0);

        // randomized traffic
        for (int cyc = 0; cyc < 800; cyc++) begin
            @(negedge clk);
            mux_in    = 8'($urandom);
            start     = ($urandom_range(0, 7) == 0);
            msb_first = 1'($urandom);
            rst       = ($urandom_range(0, 149) == 0);
        end
        start = 1'b0;
        rst = 1'b0;
        idle(30);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
